// File: rtl/inv_mix_column_if.sv
// Handshake and state bus for the inv_mix_column block.
// With INV_MIX_COLUMN_FWD_EN defined the bus also carries the inverse mode select.
interface inv_mix_column_if;
   logic       start;
   logic [7:0] state_array_in  [0:15];
   logic [7:0] state_array_out [0:15];
   logic       busy;
   logic       done;
`ifdef INV_MIX_COLUMN_FWD_EN
   logic       inverse;

   modport master (
      output start, state_array_in, inverse,
      input  state_array_out, busy, done
   );

   modport slave (
      input  start, state_array_in, inverse,
      output state_array_out, busy, done
   );
`else
   modport master (
      output start, state_array_in,
      input  state_array_out, busy, done
   );

   modport slave (
      input  start, state_array_in,
      output state_array_out, busy, done
   );
`endif
endinterface

// File: rtl/inv_mix_column.sv
// AES InvMixColumns over a captured 16-byte state, one column per clock.
// Optional INV_MIX_COLUMN_FWD_EN adds forward MixColumns selected by bus.inverse.
module inv_mix_column (
   input logic             clk,
   input logic             rst,
   inv_mix_column_if.slave bus
);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t     state;
   logic [1:0] col;
   logic       busy_q;
   logic       done_q;
   logic [7:0] buf_q   [0:15];
   logic [7:0] out_q   [0:15];
   logic [7:0] col_res [0:3];
   logic       mode_inv;

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   // Coefficients are at most 4 bits, so a product is the XOR of a*{1,2,4,8}.
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [3:0] k);
      logic [7:0] x2, x4, x8;
      x2 = xtime(a);
      x4 = xtime(x2);
      x8 = xtime(x4);
      return (k[0] ? a  : 8'h00) ^ (k[1] ? x2 : 8'h00) ^
             (k[2] ? x4 : 8'h00) ^ (k[3] ? x8 : 8'h00);
   endfunction

   // Circulant row entry for offset d = (input byte - output byte) mod 4.
   function automatic logic [3:0] coef(input logic [1:0] d, input logic inv);
      logic [3:0] c;
      if (inv) begin
         case (d)
            2'd0:    c = 4'he;
            2'd1:    c = 4'hb;
            2'd2:    c = 4'hd;
            default: c = 4'h9;
         endcase
      end else begin
         case (d)
            2'd0:    c = 4'h2;
            2'd1:    c = 4'h3;
            default: c = 4'h1;
         endcase
      end
      return c;
   endfunction

`ifdef INV_MIX_COLUMN_FWD_EN
   logic inv_q;
   assign mode_inv = inv_q;
`else
   assign mode_inv = 1'b1;
`endif

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         col_res[i] = 8'h00;
         for (int j = 0; j < 4; j++) begin
            col_res[i] = col_res[i] ^
                         gf_mul(buf_q[{col, 2'(j)}], coef(2'(j - i), mode_inv));
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         col    <= 2'd0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         for (int k = 0; k < 16; k++) begin
            buf_q[k] <= 8'h00;
            out_q[k] <= 8'h00;
         end
`ifdef INV_MIX_COLUMN_FWD_EN
         inv_q  <= 1'b1;
`endif
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  buf_q  <= bus.state_array_in;
                  col    <= 2'd0;
                  busy_q <= 1'b1;
                  state  <= CALC;
`ifdef INV_MIX_COLUMN_FWD_EN
                  inv_q  <= bus.inverse;
`endif
               end
            end
            CALC: begin
               for (int k = 0; k < 4; k++) begin
                  out_q[{col, 2'(k)}] <= col_res[k];
               end
               col <= col + 2'd1;
               if (col == 2'd3) begin
                  state  <= DONE;
                  done_q <= 1'b1;
               end
            end
            DONE: begin
               busy_q <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.state_array_out = out_q;
   assign bus.busy            = busy_q;
   assign bus.done            = done_q;

endmodule

// File: tb/tb_inv_mix_column.sv
// Directed bench for inv_mix_column using hand-computed AES column vectors.
module tb_inv_mix_column;
   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;
   int   done_cnt = 0;
   int   e;
   int   dc;
   int   busy_cycles;

   inv_mix_column_if bus();

   inv_mix_column dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (bus.done === 1'b1) done_cnt++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] out_col(input int c);
      return {bus.state_array_out[4*c], bus.state_array_out[4*c+1],
              bus.state_array_out[4*c+2], bus.state_array_out[4*c+3]};
   endfunction

   task automatic set_col(input int c, input logic [31:0] v);
      bus.state_array_in[4*c]   = v[31:24];
      bus.state_array_in[4*c+1] = v[23:16];
      bus.state_array_in[4*c+2] = v[15:8];
      bus.state_array_in[4*c+3] = v[7:0];
   endtask

   task automatic set_all(input logic [31:0] v);
      for (int c = 0; c < 4; c++) set_col(c, v);
   endtask

   task automatic set_mixed();
      set_col(0, 32'h9fdc589d);
      set_col(1, 32'hd5d5d7d6);
      set_col(2, 32'h01010101);
      set_col(3, 32'hc6c6c6c6);
   endtask

   // Ends at the falling edge after the start edge N.
   task automatic pulse_start();
      @(negedge clk);
      bus.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   // Counts rising edges until done is seen high; 20 means it never came.
   task automatic wait_done(output int edges);
      logic found;
      edges = 0;
      found = 1'b0;
      while (!found && edges < 20) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
         if (bus.done === 1'b1) found = 1'b1;
      end
   endtask

   initial begin
      rst       = 1'b1;
      bus.start = 1'b0;
`ifdef INV_MIX_COLUMN_FWD_EN
      bus.inverse = 1'b1;
`endif
      set_all(32'h0);
      repeat (2) @(negedge clk);
      check("rst_busy", {31'd0, bus.busy}, 32'd0);
      check("rst_done", {31'd0, bus.done}, 32'd0);
      check("rst_out0", out_col(0), 32'h0);

      // Start presented together with reset release, known vector
      set_all(32'h8e4da1bc);
      rst       = 1'b0;
      bus.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      check("start_after_rst", {31'd0, bus.busy}, 32'd1);
      dc = done_cnt;
      wait_done(e);
      check("known_latency", e, 4);
      for (int c = 0; c < 4; c++) check($sformatf("known_col%0d", c), out_col(c), 32'hdb135345);
      @(posedge clk);
      @(negedge clk);
      check("known_done_width", {31'd0, bus.done}, 32'd0);
      check("known_idle_busy", {31'd0, bus.busy}, 32'd0);
      check("known_done_cnt", done_cnt - dc, 1);

      // Mixed columns, one column written per edge
      set_mixed();
      dc = done_cnt;
      pulse_start();
      busy_cycles = bus.busy ? 1 : 0;
      @(posedge clk);
      @(negedge clk);
      if (bus.busy) busy_cycles++;
      check("mixed_col0_first", out_col(0), 32'hf20a225c);
      check("mixed_col1_held", out_col(1), 32'hdb135345);
      for (int n = 0; n < 20 && bus.busy; n++) begin
         @(posedge clk);
         @(negedge clk);
         if (bus.busy) busy_cycles++;
      end
      check("mixed_busy_cycles", busy_cycles, 5);
      check("mixed_done_cnt", done_cnt - dc, 1);
      check("mixed_col0", out_col(0), 32'hf20a225c);
      check("mixed_col1", out_col(1), 32'hd4d4d4d5);
      check("mixed_col2", out_col(2), 32'h01010101);
      check("mixed_col3", out_col(3), 32'hc6c6c6c6);

      // Input changes and start held high during the run
      set_all(32'h8e4da1bc);
      dc = done_cnt;
      @(negedge clk);
      bus.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      set_mixed();
      repeat (5) begin
         @(posedge clk);
         @(negedge clk);
      end
      check("hold_idle_busy", {31'd0, bus.busy}, 32'd0);
      check("hold_done_cnt", done_cnt - dc, 1);
      for (int c = 0; c < 4; c++) check($sformatf("hold_col%0d", c), out_col(c), 32'hdb135345);
      @(posedge clk);
      @(negedge clk);
      check("b2b_accept", {31'd0, bus.busy}, 32'd1);
      bus.start = 1'b0;
      wait_done(e);
      check("b2b_latency", e, 4);
      check("b2b_col0", out_col(0), 32'hf20a225c);
      check("b2b_col3", out_col(3), 32'hc6c6c6c6);

      // Abort after two CALC edges
      set_all(32'h8e4da1bc);
      pulse_start();
      @(posedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("abort_busy", {31'd0, bus.busy}, 32'd0);
      check("abort_done", {31'd0, bus.done}, 32'd0);
      check("abort_col0", out_col(0), 32'h0);
      check("abort_col3", out_col(3), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      dc  = done_cnt;
      repeat (6) @(negedge clk);
      check("abort_no_done", done_cnt - dc, 0);
      pulse_start();
      wait_done(e);
      check("rerun_latency", e, 4);
      for (int c = 0; c < 4; c++) check($sformatf("rerun_col%0d", c), out_col(c), 32'hdb135345);

`ifdef INV_MIX_COLUMN_FWD_EN
      set_all(32'hdb135345);
      bus.inverse = 1'b0;
      pulse_start();
      wait_done(e);
      check("fwd_latency", e, 4);
      check("fwd_col0", out_col(0), 32'h8e4da1bc);
      check("fwd_col3", out_col(3), 32'h8e4da1bc);
      bus.inverse = 1'b1;
      pulse_start();
      wait_done(e);
      check("inv_latency", e, 4);
      check("inv_col0", out_col(0), 32'h32a41d55);
      check("inv_col3", out_col(3), 32'h32a41d55);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/inv_mix_column.md
INV_MIX_COLUMN -- requirements
Module: inv_mix_column

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; clk and rst are the only clock and reset ports.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 start  input  1  request to transform the current state_array_in; sampled on rising clk.
REQ-005 state_array_in  input  8 x [0:15]  AES state; column c is bytes 4c..4c+3, byte 4c is row 0.
REQ-006 state_array_out  output  8 x [0:15]  registered result, same byte ordering as the input.
REQ-007 busy  output  1  high while a transform is in progress or completing.
REQ-008 done  output  1  one-cycle pulse; state_array_out is complete and valid.

Function
REQ-009 The FSM SHALL have three states: IDLE, CALC and DONE, plus a 2-bit column counter col.
REQ-010 In IDLE with start=1 at a rising edge, the block SHALL capture all 16 input bytes into an internal buffer, set col=0 and enter CALC.
REQ-011 In IDLE with start=0, the FSM SHALL remain in IDLE.
REQ-012 In CALC, each rising edge SHALL write the four InvMixColumns bytes of column col from the buffer into state_array_out[4col..4col+3] and increment col.
REQ-013 The edge that writes col=3 SHALL move the FSM to DONE, with col wrapping to 0.
REQ-014 In DONE, done SHALL be 1 for exactly one cycle, and the next edge SHALL return the FSM to IDLE.
REQ-015 Latency: with start sampled at edge N, columns are written at edges N+1..N+4 and done is high between edges N+4 and N+5.
REQ-016 busy SHALL be 1 in CALC and in DONE, and 0 in IDLE.
REQ-017 start SHALL be ignored in CALC and in DONE; the buffer SHALL NOT change after capture.
REQ-018 Changes to state_array_in after capture SHALL NOT affect the result.
REQ-019 The InvMixColumns column math, for input a0..a3, SHALL be:
  - o0 = 0e*a0 ^ 0b*a1 ^ 0d*a2 ^ 09*a3
  - o1 = 09*a0 ^ 0e*a1 ^ 0b*a2 ^ 0d*a3
  - o2 = 0d*a0 ^ 09*a1 ^ 0e*a2 ^ 0b*a3
  - o3 = 0b*a0 ^ 0d*a1 ^ 09*a2 ^ 0e*a3
REQ-020 All multiplies SHALL be GF(2^8) modulo x^8+x^4+x^3+x+1 (0x11B), built from xtime chains with 8-bit results and no carry-out.
REQ-021 Between runs, state_array_out SHALL hold its last value, and SHALL change only one column per CALC edge.
REQ-022 Back-to-back operation: start asserted in the first IDLE cycle after DONE SHALL be accepted, giving at most one transform per 6 cycles.

Reset
REQ-023 Asserting rst SHALL immediately force the FSM to IDLE, col=0, busy=0, done=0, and clear state_array_out and the buffer to 8'h00.
REQ-024 rst asserted during CALC or DONE SHALL abort the run, and done SHALL NOT pulse for the aborted run.
REQ-025 After rst deasserts, the first start SHALL be accepted at the next rising edge.

Configuration
REQ-026 The macro INV_MIX_COLUMN_FWD_EN SHALL control one optional feature: forward-mode support.
REQ-027 With INV_MIX_COLUMN_FWD_EN defined:
  - the block SHALL add an input port inverse (1 bit), captured with start;
  - inverse=1 SHALL select InvMixColumns;
  - inverse=0 SHALL select forward MixColumns (02,03,01,01 circulant), with identical timing.
REQ-028 Without INV_MIX_COLUMN_FWD_EN, the inverse port SHALL NOT exist and only InvMixColumns SHALL be implemented.

Verification
REQ-029 Reset: assert rst mid-cycle -> all outputs 0 immediately; start at the first edge after release is accepted.
REQ-030 Known vector: every column = 8e 4d a1 bc, start pulse -> every output column = db 13 53 45; done is high exactly 4 edges after the start edge.
REQ-031 Mixed columns: columns {9f dc 58 9d}, {d5 d5 d7 d6}, {01 01 01 01}, {c6 c6 c6 c6}, in that order ->
  - outputs {f2 0a 22 5c}, {d4 d4 d4 d5}, {01 01 01 01}, {c6 c6 c6 c6};
  - busy is high for 5 cycles.
REQ-032 Stimulus change and start ignored:
  - change state_array_in and hold start=1 throughout CALC -> result reflects only the captured data;
  - exactly one done pulse occurs;
  - the next start is accepted in the IDLE cycle after DONE.
REQ-033 Abort: assert rst after 2 CALC edges -> no done pulse; output is 0; a following run on 8e 4d a1 bc completes correctly.
REQ-034 With INV_MIX_COLUMN_FWD_EN defined:
  - inverse=0 on column db 13 53 45 -> 8e 4d a1 bc;
  - inverse=1 on the same column -> the inverse result, with the same latency.
